// File: rtl/inst_word_encoder.sv
// Issue-side instruction word encoder: encodes compact commands into
// 32-bit words, buffers them in a FIFO and supports a repeat command.
module inst_word_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_cmd_valid,
  output logic             io_cmd_ready,
  input  logic [1:0]       io_cmd_op,
  input  logic [31:0]      io_cmd_raw,
  input  logic [3:0]       io_cmd_count,
  output logic             io_inst_valid,
  input  logic             io_inst_ready,
  output logic [31:0]      io_inst_bits,
  output logic [CNT_W-1:0] io_issued,
  output logic             io_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [31:0] WORD_A = 32'h0000257b;
  localparam logic [31:0] WORD_B = 32'h0000277b;

  typedef enum logic {
    S_IDLE,
    S_REPEAT
  } state_t;

  state_t        state, state_n;
  logic [3:0]    rem, rem_n;
  logic [31:0]   last_word, last_n;
  logic [31:0]   enc_word;
  logic [31:0]   push_word;
  logic          push, pop, full, empty;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   mem [DEPTH];

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign pop   = !empty && io_inst_ready;

  assign io_inst_valid = !empty;
  assign io_inst_bits  = empty ? 32'h0 : mem[rd_ptr];
  assign io_busy       = (state != S_IDLE) || !empty;

  always_comb begin
    enc_word = io_cmd_raw;
    unique case (io_cmd_op)
      2'd0:    enc_word = WORD_A;
      2'd1:    enc_word = WORD_B;
      default: enc_word = io_cmd_raw;
    endcase
  end

  always_comb begin
    state_n      = state;
    rem_n        = rem;
    last_n       = last_word;
    push         = 1'b0;
    push_word    = last_word;
    io_cmd_ready = 1'b0;
    unique case (state)
      S_IDLE: begin
        io_cmd_ready = !full;
        if (io_cmd_valid && !full) begin
          push = 1'b1;
          if (io_cmd_op == 2'd3) begin
            rem_n = io_cmd_count;
            if (io_cmd_count != 4'd0)
              state_n = S_REPEAT;
          end else begin
            push_word = enc_word;
            last_n    = enc_word;
          end
        end
      end
      S_REPEAT: begin
        if (!full) begin
          push  = 1'b1;
          rem_n = rem - 4'd1;
          if (rem == 4'd1)
            state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rem       <= 4'd0;
      last_word <= WORD_A;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      last_word <= last_n;
    end
  end

  // Storage needs no reset; validity is governed by count.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      io_issued <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        io_issued <= io_issued + CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_word_encoder.sv
// Directed bench for inst_word_encoder: ordering, backpressure,
// repeat, reset abort and counter wrap.
module tb_inst_word_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_raw;
  logic [3:0]  cmd_count;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_bits;
  logic [7:0]  issued;
  logic        busy;

  logic        cmd_ready2;
  logic        inst_valid2;
  logic [31:0] inst_bits2;
  logic [1:0]  issued2;
  logic        busy2;

  int total = 0;
  int bad   = 0;
  logic [31:0] got_q [$];

  always #5 clk = ~clk;

  inst_word_encoder #(.DEPTH(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset),
    .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready),
    .io_cmd_op(cmd_op), .io_cmd_raw(cmd_raw),
    .io_cmd_count(cmd_count),
    .io_inst_valid(inst_valid), .io_inst_ready(inst_ready),
    .io_inst_bits(inst_bits), .io_issued(issued),
    .io_busy(busy)
  );

  inst_word_encoder #(.DEPTH(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .io_cmd_valid(cmd_valid), .io_cmd_ready(cmd_ready2),
    .io_cmd_op(cmd_op), .io_cmd_raw(cmd_raw),
    .io_cmd_count(cmd_count),
    .io_inst_valid(inst_valid2), .io_inst_ready(inst_ready),
    .io_inst_bits(inst_bits2), .io_issued(issued2),
    .io_busy(busy2)
  );

  // Records every handoff; the pop happens at the following rising edge.
  always @(negedge clk)
    if (!reset && inst_valid && inst_ready)
      got_q.push_back(inst_bits);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid  = 1'b0;
    inst_ready = 1'b0;
    reset      = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    got_q.delete();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk(tag, {31'b0, busy}, 32'd0);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] raw,
                      input logic [3:0] cnt);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_raw   = raw;
    cmd_count = cnt;
  endtask

  initial begin
    int nok;
    int lows;
    int n;
    logic wrap;
    logic [1:0] prev;
    cmd_op    = 2'd0;
    cmd_raw   = 32'h0;
    cmd_count = 4'd0;

    // Reset state
    do_reset();
    chk("rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst inst_bits", inst_bits, 32'h0);
    chk("rst issued", {24'b0, issued}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);

    // Back-to-back A, B, RAW with ready held high
    inst_ready = 1'b1;
    send(2'd0, 32'h0, 4'd0);
    step();
    chk("t1 valid", {31'b0, inst_valid}, 32'd1);
    chk("t1 word0", inst_bits, 32'h0000257b);
    send(2'd1, 32'h0, 4'd0);
    step();
    chk("t1 word1", inst_bits, 32'h0000277b);
    send(2'd2, 32'hdeadbeef, 4'd0);
    step();
    chk("t1 word2", inst_bits, 32'hdeadbeef);
    cmd_valid = 1'b0;
    step();
    chk("t1 empty", {31'b0, inst_valid}, 32'd0);
    chk("t1 issued", {24'b0, issued}, 32'd3);
    chk("t1 busy", {31'b0, busy}, 32'd0);

    // Backpressure: five INST_B into a four-entry FIFO
    do_reset();
    send(2'd1, 32'h0, 4'd0);
    for (int i = 0; i < 4; i++) step();
    chk("t2 full ready", {31'b0, cmd_ready}, 32'd0);
    step();
    chk("t2 still full", {31'b0, cmd_ready}, 32'd0);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("t2 slot freed", {31'b0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("t2 refull", {31'b0, cmd_ready}, 32'd0);
    inst_ready = 1'b1;
    drain("t2 drain");
    nok = 0;
    foreach (got_q[i]) if (got_q[i] == 32'h0000277b) nok++;
    chk("t2 count", got_q.size(), 32'd5);
    chk("t2 words", nok, 32'd5);

    // RAW then REPEAT count=3
    do_reset();
    inst_ready = 1'b1;
    send(2'd2, 32'h12345678, 4'd0);
    step();
    send(2'd3, 32'h0, 4'd3);
    step();
    cmd_valid = 1'b0;
    lows = 0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      lows++;
      step();
      n++;
    end
    chk("t3 ready low", lows, 32'd3);
    drain("t3 drain");
    nok = 0;
    foreach (got_q[i]) if (got_q[i] == 32'h12345678) nok++;
    chk("t3 count", got_q.size(), 32'd5);
    chk("t3 words", nok, 32'd5);
    chk("t3 issued", {24'b0, issued}, 32'd5);

    // REPEAT count=0 straight after reset
    do_reset();
    inst_ready = 1'b1;
    send(2'd3, 32'h0, 4'd0);
    step();
    cmd_valid = 1'b0;
    nok = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_ready) nok++;
      step();
    end
    chk("t4 stays idle", nok, 32'd5);
    chk("t4 count", got_q.size(), 32'd1);
    chk("t4 word", (got_q.size() > 0) ? got_q[0] : 32'hx, 32'h0000257b);
    chk("t4 issued", {24'b0, issued}, 32'd1);

    // REPEAT 15 with toggling ready; reset on the sixth word
    do_reset();
    send(2'd3, 32'h0, 4'd15);
    step();
    cmd_valid = 1'b0;
    n = 0;
    while (!(issued == 8'd5 && inst_valid) && n < 60) begin
      inst_ready = ~inst_ready;
      step();
      n++;
    end
    chk("t5 reach word6", {31'b0, (n < 60)}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t5 async valid", {31'b0, inst_valid}, 32'd0);
    chk("t5 async bits", inst_bits, 32'h0);
    chk("t5 async issued", {24'b0, issued}, 32'd0);
    chk("t5 async busy", {31'b0, busy}, 32'd0);
    chk("t5 async ready", {31'b0, cmd_ready}, 32'd1);
    step();
    reset = 1'b0;
    step();
    got_q.delete();
    inst_ready = 1'b1;
    send(2'd0, 32'h0, 4'd0);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 25; i++) step();
    chk("t5 count", got_q.size(), 32'd1);
    chk("t5 word", (got_q.size() > 0) ? got_q[0] : 32'hx, 32'h0000257b);
    chk("t5 issued", {24'b0, issued}, 32'd1);

    // Counter wrap on the CNT_W=2 instance
    do_reset();
    inst_ready = 1'b1;
    wrap = 1'b0;
    prev = issued2;
    send(2'd2, 32'hcafef00d, 4'd0);
    for (int i = 0; i < 9; i++) begin
      if (i == 5) cmd_valid = 1'b0;
      step();
      if (prev == 2'd3 && issued2 == 2'd0) wrap = 1'b1;
      prev = issued2;
    end
    chk("t6 issued2", {30'b0, issued2}, 32'd1);
    chk("t6 wrap", {31'b0, wrap}, 32'd1);
    chk("t6 issued", {24'b0, issued}, 32'd5);
    chk("t6 idle2", {29'b0, cmd_ready2, inst_valid2, busy2}, 32'd4);
    chk("t6 bits2", inst_bits2, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_word_encoder.md
# inst_word_encoder

Issue-side counterpart to the instruction decoder. Accepts compact issue commands, encodes them into 32-bit instruction words, and buffers them in a small FIFO. Words are presented to the decode stage over a ready/valid interface. It also supports a repeat command that re-issues the last encoded word a programmed number of times, so a bench can drive decode-stage logic with scripted instruction streams.

## Interface
Parameters:
- DEPTH, 4, output FIFO entries; power of two, ≥2
- CNT_W, 8, width of issued-word counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- io_cmd_valid  in  1  command present
- io_cmd_ready  out  1  block accepts a command this cycle
- io_cmd_op  in  2  0=INST_A, 1=INST_B, 2=RAW, 3=REPEAT
- io_cmd_raw  in  32  word for RAW; ignored otherwise
- io_cmd_count  in  4  extra repeats for REPEAT; ignored otherwise
- io_inst_valid  out  1  FIFO head valid
- io_inst_ready  in  1  decode stage consumes head
- io_inst_bits  out  32  FIFO head word; 32'h0 when empty
- io_issued  out  CNT_W  count of words handed off (valid&&ready), wraps
- io_busy  out  1  FSM not IDLE or FIFO non-empty

## Operation
- Encoding:
  - INST_A → 32'h0000257b
  - INST_B → 32'h0000277b
  - RAW → io_cmd_raw
- last_word register:
  - Updated with the encoded word on every accepted INST_A/INST_B/RAW.
  - Reset value is 32'h0000257b.
- FSM states: IDLE, REPEAT; 4-bit remaining counter `rem`.
- In IDLE:
  - io_cmd_ready = !full, from registered FIFO occupancy; no combinational path from io_inst_ready.
  - Accept = io_cmd_valid && io_cmd_ready.
  - Accepted INST_A/INST_B/RAW: push the encoded word and stay in IDLE.
  - Accepted REPEAT: push last_word once and set rem = io_cmd_count.
  - If io_cmd_count==0, stay in IDLE; otherwise go to REPEAT.
- In REPEAT:
  - io_cmd_ready = 0.
  - Each cycle with !full: push last_word and decrement rem.
  - The push made with rem==1 returns the FSM to IDLE. Total pushes = io_cmd_count+1.
- FIFO behaviour:
  - Push and pop in the same cycle leave occupancy unchanged.
  - When full, a pop in the same cycle does not enable a push; the freed slot is usable next cycle.
  - Pointers wrap modulo DEPTH; occupancy is tracked with a DEPTH+1-valued counter.
- io_issued increments on each io_inst_valid && io_inst_ready and wraps from 2^CNT_W−1 to 0.
- Reset values:
  - State and storage: FIFO empty, state IDLE, rem=0, last_word=32'h257b.
  - Outputs: io_cmd_ready=1, io_inst_valid=0, io_inst_bits=0, io_issued=0, io_busy=0.
- Reset asserted mid-REPEAT or with FIFO occupied aborts everything: remaining repeats are dropped and the FIFO is flushed.

## Timing
- Command→word latency is 1 cycle. A command accepted at edge N into an empty FIFO gives io_inst_valid=1 and the word on io_inst_bits after edge N. There is no same-cycle bypass.
- Throughput:
  - One push per cycle, one pop per cycle.
  - Sustained 1 word/cycle when io_inst_ready is held high.
- io_inst_valid, once high, holds with stable io_inst_bits until popped.
- io_busy deasserts the cycle after the last pop with FSM in IDLE.
- io_cmd_ready is low for the cycles spent in REPEAT. It returns high the cycle after the final repeat push, provided the FIFO is not full.

## Test plan
- Reset, then INST_A, INST_B, RAW 32'hdeadbeef back-to-back with io_inst_ready=1:
  - Output 32'h257b, 32'h277b, 32'hdeadbeef on consecutive cycles, starting 1 cycle after the first accept.
  - io_issued=3.
- io_inst_ready=0 with DEPTH=4, offering 5 INST_B commands:
  - io_cmd_ready drops after 4 accepts.
  - The 5th is accepted only the cycle after the first pop.
  - No word is lost or duplicated.
- RAW 32'h12345678, then REPEAT count=3, io_inst_ready=1:
  - Five words total: 32'h12345678 ×1 then ×4 more.
  - io_cmd_ready=0 for 3 cycles.
  - io_busy falls after the final pop.
- REPEAT count=0 immediately after reset:
  - Exactly one 32'h257b issued.
  - FSM never leaves IDLE.
- REPEAT count=15 with io_inst_ready toggling 1/0 every cycle; assert reset on the 6th output word:
  - Outputs go to reset values asynchronously.
  - Afterwards, a new INST_A yields only 32'h257b.
  - io_issued restarts at 0.
- CNT_W=2, 5 words issued:
  - io_issued reads 1, with wrap observed after 3→0.
